// File: rtl/fxp_expr_pipe.sv
// rtl/fxp_expr_pipe.sv - 3-stage fixed-point w = x*y + y*z + x + y + z with valid/ready flow control
// Define FXP_SAT_EN to clamp out-of-range results; otherwise they wrap and sat only flags them.
module fxp_expr_pipe #(
  parameter int W  = 8,
  parameter int XF = 7,
  parameter int YF = 6,
  parameter int ZF = 7,
  parameter int OW = 17,
  parameter int OF = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [W-1:0]  z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] w,
  output logic                 sat
);

  localparam int IFR  = (XF + YF >= YF + ZF) ? XF + YF : YF + ZF;
  localparam int ACCW = 2 * W + 3;
  localparam int SHL  = (OF >= IFR) ? OF - IFR : 0;
  localparam int SHR  = (OF <  IFR) ? IFR - OF : 0;
  localparam int AW   = ACCW + SHL;
  localparam int EW   = ((AW > OW) ? AW : OW) + 1;

  logic                   v1_q, v2_q, v3_q;
  logic signed [W-1:0]    x_q, y_q, z_q;
  logic signed [ACCW-1:0] p1_q, p2_q, tx_q, ty_q, tz_q;
  logic signed [OW-1:0]   w_q;
  logic                   sat_q;

  logic advance;
  assign advance = ~v3_q | out_ready;

  // Stage 2: full-width products, then every term brought to the common fraction IFR
  logic signed [2*W-1:0]  xe, ye, ze, p1, p2;
  logic signed [ACCW-1:0] p1_d, p2_d, tx_d, ty_d, tz_d;

  assign xe   = {{W{x_q[W-1]}}, x_q};
  assign ye   = {{W{y_q[W-1]}}, y_q};
  assign ze   = {{W{z_q[W-1]}}, z_q};
  assign p1   = xe * ye;
  assign p2   = ye * ze;
  assign p1_d = {{(ACCW-2*W){p1[2*W-1]}}, p1} <<< (IFR - XF - YF);
  assign p2_d = {{(ACCW-2*W){p2[2*W-1]}}, p2} <<< (IFR - YF - ZF);
  assign tx_d = {{(ACCW-W){x_q[W-1]}}, x_q} <<< (IFR - XF);
  assign ty_d = {{(ACCW-W){y_q[W-1]}}, y_q} <<< (IFR - YF);
  assign tz_d = {{(ACCW-W){z_q[W-1]}}, z_q} <<< (IFR - ZF);

  // Stage 3: sum, align to OF (floor on right shift), range-check against OW
  logic signed [ACCW-1:0] acc;
  logic signed [EW-1:0]   acc_e, aligned;
  logic [EW-OW:0]         hi;
  logic                   ovf;
  logic signed [OW-1:0]   w_d;

  assign acc     = p1_q + p2_q + tx_q + ty_q + tz_q;
  assign acc_e   = {{(EW-ACCW){acc[ACCW-1]}}, acc};
  assign aligned = (acc_e <<< SHL) >>> SHR;
  assign hi      = aligned[EW-1:OW-1];
  assign ovf     = ~((&hi) | ~(|hi));

`ifdef FXP_SAT_EN
  assign w_d = !ovf ? aligned[OW-1:0]
             : aligned[EW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
`else
  assign w_d = aligned[OW-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      tx_q  <= '0;
      ty_q  <= '0;
      tz_q  <= '0;
      w_q   <= '0;
      sat_q <= 1'b0;
    end else if (advance) begin
      v1_q  <= in_valid;
      x_q   <= x;
      y_q   <= y;
      z_q   <= z;
      v2_q  <= v1_q;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      tx_q  <= tx_d;
      ty_q  <= ty_d;
      tz_q  <= tz_d;
      v3_q  <= v2_q;
      w_q   <= w_d;
      sat_q <= ovf;
    end
  end

  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign w         = w_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fxp_expr_pipe.sv
// tb/tb_fxp_expr_pipe.sv - randomized scoreboard bench for fxp_expr_pipe (honours FXP_SAT_EN)
module tb_fxp_expr_pipe;

  localparam int W  = 8;
  localparam int XF = 7;
  localparam int YF = 6;
  localparam int ZF = 7;
  localparam int OW = 17;
  localparam int OF = 15;
  localparam int IFR = (XF + YF > YF + ZF) ? XF + YF : YF + ZF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x = '0, y = '0, z = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] w;
  logic          sat;

  int tests_run = 0;
  int tests_failed = 0;
  int n_out = 0;
  logic [OW:0] exp_q[$];

  always #5 clk = ~clk;

  fxp_expr_pipe #(.W(W), .XF(XF), .YF(YF), .ZF(ZF), .OW(OW), .OF(OF)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .w(w), .sat(sat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Real-valued expression evaluated as integers at IFR fraction bits, then rescaled to OF.
  function automatic logic [OW:0] model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                        input logic [W-1:0] zv);
    longint xs, ys, zs, sum, a, maxv, minv, r;
    logic   s;
    xs   = longint'($signed(xv));
    ys   = longint'($signed(yv));
    zs   = longint'($signed(zv));
    sum  = ((xs * ys) <<< (IFR - XF - YF)) + ((ys * zs) <<< (IFR - YF - ZF))
         + (xs <<< (IFR - XF)) + (ys <<< (IFR - YF)) + (zs <<< (IFR - ZF));
    if (OF >= IFR) a = sum <<< (OF - IFR);
    else           a = sum >>> (IFR - OF);
    maxv = (64'sd1 <<< (OW - 1)) - 1;
    minv = -(64'sd1 <<< (OW - 1));
    s    = (a > maxv) || (a < minv);
    r    = a;
`ifdef FXP_SAT_EN
    if (a > maxv) r = maxv;
    if (a < minv) r = minv;
`endif
    return {s, r[OW-1:0]};
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          logic [OW:0] e;
          e = exp_q.pop_front();
          check_eq("stream_w", 32'(w), 32'(e[OW-1:0]));
          check_eq("stream_sat", 32'(sat), 32'(e[OW]));
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y, z));
    end
  end

  // Presents one set and waits (bounded) until it is accepted; optionally jitters out_ready.
  task automatic push(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [W-1:0] zv,
                      input bit rand_ready);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    x = xv; y = yv; z = zv; in_valid = 1'b1;
    while (!acc && n < 200) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check_eq("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic [W-1:0] zv, input logic [OW-1:0] ew, input logic es);
    out_ready = 1'b1;
    x = xv; y = yv; z = zv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_w"}, 32'(w), 32'(ew));
    check_eq({tag, "_sat"}, 32'(sat), 32'(es));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] bx[5], by[5], bz[5];
    logic [OW:0]  first;
    int           accepted, idx, base, stalls, seen;

    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_w", 32'(w), 32'd0);
    check_eq("rst_sat", 32'(sat), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    directed("basic", 8'h40, 8'h20, 8'h00, 17'h0A000, 1'b0);
    directed("negative", 8'h80, 8'h40, 8'h00, 17'h18000, 1'b0);
`ifdef FXP_SAT_EN
    directed("overflow", 8'h7F, 8'h7F, 8'h7F, 17'h0FFFF, 1'b1);
`else
    directed("overflow", 8'h7F, 8'h7F, 8'h7F, 17'h1F408, 1'b1);
`endif
    directed("neg_floor", 8'h80, 8'h80, 8'h80, 17'(model(8'h80, 8'h80, 8'h80)), 1'b0);

    // Backpressure: five sets offered while downstream is stalled
    for (int i = 0; i < 5; i++) begin
      bx[i] = 8'($urandom); by[i] = 8'($urandom); bz[i] = 8'($urandom);
    end
    first = model(bx[0], by[0], bz[0]);
    base = n_out;
    out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      idx = (accepted < 5) ? accepted : 4;
      x = bx[idx]; y = by[idx]; z = bz[idx]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk); #1;
    end
    check_eq("bp_accepted", 32'(accepted), 32'd3);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_w", 32'(w), 32'(first[OW-1:0]));
    check_eq("bp_hold_sat", 32'(sat), 32'(first[OW]));
    out_ready = 1'b1;
    push(bx[3], by[3], bz[3], 1'b0);
    push(bx[4], by[4], bz[4], 1'b0);
    drain();
    check_eq("bp_count", 32'(n_out - base), 32'd5);

    // Streaming: 100 back-to-back sets with out_ready held high
    base = n_out;
    stalls = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      x = 8'($urandom); y = 8'($urandom); z = 8'($urandom); in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("stream_stalls", 32'(stalls), 32'd0);
    check_eq("stream_count", 32'(n_out - base), 32'd100);

    // Random backpressure
    for (int i = 0; i < 60; i++) push(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    drain();

    // Reset with three samples in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    in_valid = 1'b0;
    check_eq("inflight_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_w", 32'(w), 32'd0);
    check_eq("midrst_sat", 32'(sat), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("no_stale", 32'(seen), 32'd0);
    directed("after_rst", 8'h40, 8'h20, 8'h00, 17'h0A000, 1'b0);

    drain();
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
